my_assoc_buffer_arbiter: RTL and testbench
==========================================

Name: my_assoc_buffer_arbiter

Overview:
- Round-robin command arbiter that shares one associative buffer command port among NUM_REQ independent requesters.
- Each requester presents one operation (INCR, LOAD or CLR) with key and data, and holds it until acknowledged.
- The arbiter issues exactly one command per grant, then drives NOP for a guard interval before the next grant.
- Sits between the button/host front-ends and the associative buffer, replacing direct ctrl drive.

Parameters:
- NUM_REQ, 3, number of requesters (2..4).
- IDX_WIDTH, 2, width of grant index; 2**IDX_WIDTH >= NUM_REQ.
- KEY_WIDTH, 4, key width per requester and to buffer.
- DATA_WIDTH, 2, data width per requester and to buffer.
- GUARD_CYCLES, 1, NOP cycles after each issued command (1..15).
- CNT_WIDTH, 8, width of issued-command counter.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  request per requester; held high until matching ack.
- req_op  input  2*NUM_REQ  op per requester i at [2i+1:2i]: 00 INCR, 01 LOAD, 10 CLR, 11 reserved.
- req_key  input  KEY_WIDTH*NUM_REQ  key per requester, same slicing.
- req_data  input  DATA_WIDTH*NUM_REQ  data per requester, same slicing.
- ack  output  NUM_REQ  one-cycle pulse to the granted requester in its issue cycle.
- buf_ctrl  output  3  buffer command code (associative buffer NOP/INCR/LOAD/CLR encodings).
- buf_key  output  KEY_WIDTH  key to buffer, valid in issue cycle.
- buf_data  output  DATA_WIDTH  data to buffer, valid in issue cycle.
- busy  output  1  high in ISSUE and GUARD.
- grant_idx  output  IDX_WIDTH  index of last granted requester.
- issued_count  output  CNT_WIDTH  number of non-reserved commands issued; wraps modulo 2**CNT_WIDTH.

Behaviour:
- All outputs registered. Reset values: ack=0, buf_ctrl=NOP, buf_key=0, buf_data=0, busy=0, grant_idx=0, issued_count=0. Internal state: FSM=IDLE, rr_ptr=0, guard counter=0.
- FSM states: IDLE, ISSUE, GUARD.
- IDLE: if any req bit is high at edge k, select winner w, the first requester with req high scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - Also at edge k: latch req_op/key/data of w into buf_*, ack[w]=1, grant_idx=w, rr_ptr=(w+1) mod NUM_REQ, FSM→ISSUE.
  - Latency: req sampled at edge k → command visible and ack high during cycle k+1.
- Op mapping: INCR, LOAD and CLR map to their buffer codes. Reserved 11 is acked but drives buf_ctrl=NOP and is not counted.
- ISSUE (exactly 1 cycle):
  - At exit edge: ack=0, buf_ctrl=NOP, buf_key/buf_data hold their values.
  - issued_count increments at this edge if the op was not reserved.
  - Guard counter loads GUARD_CYCLES-1; FSM→GUARD.
- GUARD: req is ignored. Counter decrements each cycle; when it is 0, FSM→IDLE at that edge. GUARD therefore lasts exactly GUARD_CYCLES cycles.
- Minimum spacing between issued commands: GUARD_CYCLES+2 cycles.
- Requester contract: deassert req, or present a new request, no earlier than the edge ending the ack cycle. The guard interval guarantees no double issue.
- No request in IDLE: stay in IDLE with all outputs held at NOP/0 pulses.
- Simultaneous requests: only one winner per arbitration; the others wait, their req held. Fairness: each waiting requester is served within NUM_REQ grants.
- rr_ptr changes only on grant; a request dropped before grant is lost silently.
- rst high in any state, including ISSUE with ack high: the next cycle shows reset values. A pending command is not issued and is not counted.
- req bits at index >= NUM_REQ do not exist; rr_ptr never exceeds NUM_REQ-1.

Test Plan:
- Reset, then req=001, op0=01 (LOAD), key0=4'hA, data0=2'b10 at edge 1 → cycle 2: buf_ctrl=LOAD, buf_key=A, buf_data=2, ack=001, busy=1. Cycle 3: NOP, busy=1. Cycle 4: busy=0, issued_count=1.
- req=111 held, all INCR, GUARD_CYCLES=1 → grants in order 0,1,2, ack pulses spaced 3 cycles apart. After the third grant, drop each req upon its ack; issued_count=3, rr_ptr returns to 0.
- rr_ptr=1 after granting 0, then req=101 → requester 2 is granted before requester 0.
- Reserved op 11 on requester 1 → ack=010 for 1 cycle, buf_ctrl stays NOP throughout, issued_count unchanged.
- rst asserted in the ISSUE cycle of a CLR → the following cycle ack=0, buf_ctrl=NOP, busy=0, issued_count=0, grant_idx=0.
- GUARD_CYCLES=3 with req=001 held continuously → CLR issued every 5 cycles. CNT_WIDTH=2 after 5 issues → issued_count=1 (wrap).

Source files
------------

// File: rtl/my_assoc_buffer_arbiter.sv
// Round-robin arbiter sharing one associative-buffer command port among NUM_REQ requesters.
// One command per grant, followed by a NOP guard interval of GUARD_CYCLES cycles.
module my_assoc_buffer_arbiter #(
  parameter int NUM_REQ      = 3,
  parameter int IDX_WIDTH    = 2,
  parameter int KEY_WIDTH    = 4,
  parameter int DATA_WIDTH   = 2,
  parameter int GUARD_CYCLES = 1,
  parameter int CNT_WIDTH    = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [2*NUM_REQ-1:0]            req_op,
  input  logic [KEY_WIDTH*NUM_REQ-1:0]    req_key,
  input  logic [DATA_WIDTH*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]              ack,
  output logic [2:0]                      buf_ctrl,
  output logic [KEY_WIDTH-1:0]            buf_key,
  output logic [DATA_WIDTH-1:0]           buf_data,
  output logic                            busy,
  output logic [IDX_WIDTH-1:0]            grant_idx,
  output logic [CNT_WIDTH-1:0]            issued_count
);

  localparam logic [2:0] CTRL_NOP  = 3'd0;
  localparam logic [2:0] CTRL_INCR = 3'd1;
  localparam logic [2:0] CTRL_LOAD = 3'd2;
  localparam logic [2:0] CTRL_CLR  = 3'd3;

  localparam logic [1:0] OP_INCR = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_CLR  = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GUARD = 2'd2
  } state_t;

  state_t                  state_r;
  logic [IDX_WIDTH-1:0]    rr_ptr_r;
  logic [3:0]              guard_cnt_r;
  logic                    reserved_r;

  logic                    win_found_s;
  logic [IDX_WIDTH-1:0]    win_idx_s;
  logic [IDX_WIDTH-1:0]    win_next_s;
  logic [1:0]              win_op_s;
  logic [KEY_WIDTH-1:0]    win_key_s;
  logic [DATA_WIDTH-1:0]   win_data_s;

  function automatic logic [2:0] map_op(input logic [1:0] op);
    case (op)
      OP_INCR: map_op = CTRL_INCR;
      OP_LOAD: map_op = CTRL_LOAD;
      OP_CLR:  map_op = CTRL_CLR;
      default: map_op = CTRL_NOP;
    endcase
  endfunction

  // Winner search: first active request scanning from rr_ptr, wrapping at NUM_REQ.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = '0;
    win_next_s  = '0;
    win_op_s    = 2'b00;
    win_key_s   = '0;
    win_data_s  = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      int cand;
      cand = (int'(rr_ptr_r) + off) % NUM_REQ;
      if (!win_found_s && req[cand]) begin
        win_found_s = 1'b1;
        win_idx_s   = IDX_WIDTH'(cand);
        win_next_s  = IDX_WIDTH'((cand + 1) % NUM_REQ);
        win_op_s    = req_op[2*cand +: 2];
        win_key_s   = req_key[KEY_WIDTH*cand +: KEY_WIDTH];
        win_data_s  = req_data[DATA_WIDTH*cand +: DATA_WIDTH];
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Arbitration FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      rr_ptr_r     <= '0;
      guard_cnt_r  <= 4'd0;
      reserved_r   <= 1'b0;
      ack          <= '0;
      buf_ctrl     <= CTRL_NOP;
      buf_key      <= '0;
      buf_data     <= '0;
      busy         <= 1'b0;
      grant_idx    <= '0;
      issued_count <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (win_found_s) begin
            ack            <= '0;
            ack[win_idx_s] <= 1'b1;
            buf_ctrl       <= map_op(win_op_s);
            buf_key        <= win_key_s;
            buf_data       <= win_data_s;
            reserved_r     <= (win_op_s == OP_RSVD);
            grant_idx      <= win_idx_s;
            rr_ptr_r       <= win_next_s;
            busy           <= 1'b1;
            state_r        <= ST_ISSUE;
          end else begin
            ack      <= '0;
            buf_ctrl <= CTRL_NOP;
          end
        end
        ST_ISSUE: begin
          ack         <= '0;
          buf_ctrl    <= CTRL_NOP;
          guard_cnt_r <= 4'(GUARD_CYCLES - 1);
          state_r     <= ST_GUARD;
          if (!reserved_r) begin
            issued_count <= issued_count + CNT_WIDTH'(1);
          end else begin
            issued_count <= issued_count;
          end
        end
        ST_GUARD: begin
          // Requests are ignored here; this is what prevents a double issue.
          if (guard_cnt_r == 4'd0) begin
            busy    <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            guard_cnt_r <= guard_cnt_r - 4'd1;
          end
        end
        default: begin
          ack      <= '0;
          buf_ctrl <= CTRL_NOP;
          busy     <= 1'b0;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_my_assoc_buffer_arbiter.sv
// Directed bench for my_assoc_buffer_arbiter: default instance plus a GUARD_CYCLES=3 / CNT_WIDTH=2 instance.
module tb_my_assoc_buffer_arbiter;

  localparam logic [2:0] NOP  = 3'd0;
  localparam logic [2:0] INCR = 3'd1;
  localparam logic [2:0] LOAD = 3'd2;
  localparam logic [2:0] CLR  = 3'd3;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] req;
  logic [5:0] req_op;
  logic [11:0] req_key;
  logic [5:0] req_data;
  logic [2:0] ack;
  logic [2:0] buf_ctrl;
  logic [3:0] buf_key;
  logic [1:0] buf_data;
  logic       busy;
  logic [1:0] grant_idx;
  logic [7:0] issued_count;

  logic [2:0] req_b;
  logic [5:0] req_op_b;
  logic [11:0] req_key_b;
  logic [5:0] req_data_b;
  logic [2:0] ack_b;
  logic [2:0] buf_ctrl_b;
  logic [3:0] buf_key_b;
  logic [1:0] buf_data_b;
  logic       busy_b;
  logic [1:0] grant_idx_b;
  logic [1:0] issued_count_b;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  my_assoc_buffer_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .req_op(req_op), .req_key(req_key),
    .req_data(req_data), .ack(ack), .buf_ctrl(buf_ctrl), .buf_key(buf_key),
    .buf_data(buf_data), .busy(busy), .grant_idx(grant_idx), .issued_count(issued_count)
  );

  my_assoc_buffer_arbiter #(.GUARD_CYCLES(3), .CNT_WIDTH(2)) dut_b (
    .clk(clk), .rst(rst), .req(req_b), .req_op(req_op_b), .req_key(req_key_b),
    .req_data(req_data_b), .ack(ack_b), .buf_ctrl(buf_ctrl_b), .buf_key(buf_key_b),
    .buf_data(buf_data_b), .busy(busy_b), .grant_idx(grant_idx_b), .issued_count(issued_count_b)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    req = 3'b000; req_op = 6'b0; req_key = 12'h0; req_data = 6'b0;
    req_b = 3'b000; req_op_b = 6'b0; req_key_b = 12'h0; req_data_b = 6'b0;
    tick(); tick();
    rst = 1'b0;
    check_val("rst_ack", ack, 3'b000);
    check_val("rst_ctrl", buf_ctrl, NOP);
    check_val("rst_key", buf_key, 4'h0);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_grant", grant_idx, 2'd0);
    check_val("rst_count", issued_count, 8'd0);

    // Single LOAD on requester 0
    req = 3'b001; req_op = 6'b00_00_01; req_key = 12'h00A; req_data = 6'b00_00_10;
    tick();
    req = 3'b000;
    check_val("t1_ctrl", buf_ctrl, LOAD);
    check_val("t1_key", buf_key, 4'hA);
    check_val("t1_data", buf_data, 2'd2);
    check_val("t1_ack", ack, 3'b001);
    check_val("t1_busy", busy, 1'b1);
    tick();
    check_val("t1_guard_ctrl", buf_ctrl, NOP);
    check_val("t1_guard_ack", ack, 3'b000);
    check_val("t1_guard_busy", busy, 1'b1);
    tick();
    check_val("t1_idle_busy", busy, 1'b0);
    check_val("t1_count", issued_count, 8'd1);

    // rr_ptr is 1: req=101 must grant 2 before 0
    req = 3'b101; req_op = 6'b00_00_00; req_key = 12'h5_3_7; req_data = 6'b11_00_01;
    tick();
    req = 3'b001;
    check_val("rr_ack2", ack, 3'b100);
    check_val("rr_grant2", grant_idx, 2'd2);
    check_val("rr_ctrl2", buf_ctrl, INCR);
    check_val("rr_key2", buf_key, 4'h5);
    check_val("rr_data2", buf_data, 2'd3);
    tick(); tick();
    check_val("rr_idle", ack, 3'b000);
    tick();
    req = 3'b000;
    check_val("rr_ack0", ack, 3'b001);
    check_val("rr_grant0", grant_idx, 2'd0);
    check_val("rr_key0", buf_key, 4'h7);
    tick(); tick();
    check_val("rr_count", issued_count, 8'd3);

    // Reset during the ISSUE cycle of a CLR on requester 1
    req = 3'b010; req_op = 6'b00_10_00; req_key = 12'h0C0;
    tick();
    req = 3'b000;
    check_val("rs_pre_ctrl", buf_ctrl, CLR);
    check_val("rs_pre_grant", grant_idx, 2'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_val("rs_ack", ack, 3'b000);
    check_val("rs_ctrl", buf_ctrl, NOP);
    check_val("rs_busy", busy, 1'b0);
    check_val("rs_count", issued_count, 8'd0);
    check_val("rs_grant", grant_idx, 2'd0);

    // All three requesting INCR: grants 0,1,2 three cycles apart
    req = 3'b111; req_op = 6'b00_00_00; req_key = 12'h3_2_1;
    tick();
    req = 3'b110;
    check_val("all_ack0", ack, 3'b001);
    check_val("all_key0", buf_key, 4'h1);
    tick(); tick();
    check_val("all_gap1", ack, 3'b000);
    tick();
    req = 3'b100;
    check_val("all_ack1", ack, 3'b010);
    check_val("all_grant1", grant_idx, 2'd1);
    tick(); tick();
    check_val("all_gap2", ack, 3'b000);
    tick();
    req = 3'b000;
    check_val("all_ack2", ack, 3'b100);
    check_val("all_key2", buf_key, 4'h3);
    tick(); tick();
    check_val("all_count", issued_count, 8'd3);
    // rr_ptr wrapped to 0: req=011 must grant 0
    req = 3'b011;
    tick();
    req = 3'b000;
    check_val("wrap_ack", ack, 3'b001);
    check_val("wrap_grant", grant_idx, 2'd0);
    tick(); tick();

    // Reserved op on requester 1: acked, NOP, not counted
    req = 3'b010; req_op = 6'b00_11_00;
    tick();
    req = 3'b000;
    check_val("rsv_ack", ack, 3'b010);
    check_val("rsv_ctrl", buf_ctrl, NOP);
    check_val("rsv_busy", busy, 1'b1);
    tick();
    check_val("rsv_ack_off", ack, 3'b000);
    check_val("rsv_guard_ctrl", buf_ctrl, NOP);
    check_val("rsv_count", issued_count, 8'd4);
    tick();

    // GUARD_CYCLES=3 instance: held CLR issues every 5 cycles, 2-bit count wraps
    req_b = 3'b001; req_op_b = 6'b00_00_10; req_key_b = 12'h009;
    for (int cyc = 1; cyc <= 22; cyc++) begin
      tick();
      check_val($sformatf("g3_clr_c%0d", cyc), (buf_ctrl_b == CLR), ((cyc - 1) % 5) == 0);
    end
    check_val("g3_count_wrap", issued_count_b, 2'd1);
    req_b = 3'b000;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
